tiny_mem_ctrl: RTL and testbench



---
 rtl/tiny_mem_ctrl_pkg.sv | 26 ++
 rtl/tiny_mem_resp_fifo.sv | 63 ++++++
 rtl/tiny_mem_ctrl.sv | 126 ++++++++++++
 tb/tb_tiny_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_mem_ctrl_pkg.sv
// Shared types and helpers for the tiny_mem_ctrl memory path.
// Response entries are sized for the widest supported data bus (64 bits).
package tiny_mem_ctrl_pkg;

  localparam int unsigned RespDataWidth = 64;
  localparam int unsigned RespStrbWidth = RespDataWidth / 8;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef struct packed {
    logic [RespDataWidth-1:0] data;
    logic                     err;
    logic                     we;
  } resp_t;

  function automatic logic [RespDataWidth-1:0] expand_strb(input logic [RespStrbWidth-1:0] strb);
    logic [RespDataWidth-1:0] mask;
    mask = '0;
    for (int i = 0; i < RespStrbWidth; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/tiny_mem_resp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on head_o the same cycle.
// Pointers wrap modulo Depth, so any depth >= 1 works.
module tiny_mem_resp_fifo #(
  parameter int unsigned Depth = 4,
  parameter type entry_t = logic
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stored_empty, bypass, store, advance;

  function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign stored_empty = (cnt_q == '0);
  assign full_o       = (cnt_q == CntW'(Depth));
  assign empty_o      = stored_empty && !push_i;
  assign head_o       = stored_empty ? data_i : mem_q[rd_q];

  // An entry pushed and popped while nothing is stored never touches the array.
  assign bypass  = stored_empty && push_i && pop_i;
  assign store   = push_i && !bypass;
  assign advance = pop_i && !stored_empty;

  always_comb begin
    rd_d  = advance ? incr(rd_q) : rd_q;
    wr_d  = store ? incr(wr_q) : wr_q;
    cnt_d = cnt_q + CntW'(store) - CntW'(advance);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tiny_mem_ctrl.sv
// Request/grant to single-port SRAM controller with base relocation, range errors,
// fixed response latency, credit-bounded outstanding requests and optional grant throttling.
module tiny_mem_ctrl
  import tiny_mem_ctrl_pkg::*;
#(
  parameter int unsigned          AddrWidth      = 64,
  parameter int unsigned          DataWidth      = 64,
  parameter int unsigned          NumWords       = 1 << 20,
  parameter logic [AddrWidth-1:0] BaseAddr       = AddrWidth'(64'h8000_0000),
  parameter int unsigned          RespLatency    = 1,
  parameter int unsigned          MaxOutstanding = 4,
  parameter logic [15:0]          LfsrSeed       = 16'hACE1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        stall_en_i,
  input  logic                        req_i,
  output logic                        gnt_o,
  input  logic [AddrWidth-1:0]        addr_i,
  input  logic                        we_i,
  input  logic [DataWidth-1:0]        wdata_i,
  input  logic [DataWidth/8-1:0]      strb_i,
  output logic                        rvalid_o,
  input  logic                        rready_i,
  output logic [DataWidth-1:0]        rdata_o,
  output logic                        rerr_o,
  output logic                        sram_req_o,
  output logic                        sram_we_o,
  output logic [$clog2(NumWords)-1:0] sram_addr_o,
  output logic [DataWidth-1:0]        sram_wdata_o,
  output logic [DataWidth-1:0]        sram_wmask_o,
  input  logic [DataWidth-1:0]        sram_rdata_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SramAw    = $clog2(NumWords);
  localparam int unsigned ByteOffW  = $clog2(StrbWidth);
  localparam int unsigned CredW     = $clog2(MaxOutstanding + 1);
  localparam logic [AddrWidth:0] RangeBytes =
      (AddrWidth + 1)'(NumWords) * (AddrWidth + 1)'(StrbWidth);

  logic [15:0]          lfsr_q, lfsr_d;
  logic [CredW-1:0]     credits_q, credits_d;
  logic [AddrWidth-1:0] off;
  logic                 in_range, throttle, retire, accept;

  resp_t                  dl_q [RespLatency];
  resp_t                  dl_d [RespLatency];
  resp_t                  stage_out [RespLatency];
  logic [RespLatency-1:0] dl_vld_q, dl_vld_d;

  logic  resp_push, resp_full, resp_empty;
  resp_t resp_head;

  assign lfsr_d   = {lfsr_q[14:0], ^(lfsr_q & LfsrTaps)};
  assign throttle = stall_en_i && (lfsr_q[1:0] == 2'b00);

  assign off      = addr_i - BaseAddr;
  assign in_range = (addr_i >= BaseAddr) && ({1'b0, off} < RangeBytes);

  assign retire = rvalid_o && rready_i;
  // Reset gates the grant so no SRAM access can start while in reset.
  assign gnt_o  = rst_ni && !throttle && ((credits_q < CredW'(MaxOutstanding)) || retire);
  assign accept = req_i && gnt_o;

  assign sram_req_o   = accept && in_range;
  assign sram_we_o    = sram_req_o && we_i;
  assign sram_addr_o  = sram_req_o ? off[ByteOffW +: SramAw] : '0;
  assign sram_wdata_o = sram_we_o ? wdata_i : '0;
  assign sram_wmask_o = sram_we_o ? DataWidth'(expand_strb(RespStrbWidth'(strb_i))) : '0;

  always_comb begin
    for (int i = 0; i < RespLatency; i++) begin
      stage_out[i] = dl_q[i];
    end
    // Stage 0 is the cycle the SRAM returns data for the access accepted last cycle.
    stage_out[0].data = (dl_vld_q[0] && !dl_q[0].we && !dl_q[0].err) ?
                        RespDataWidth'(sram_rdata_i) : '0;

    dl_vld_d[0]  = accept;
    dl_d[0].data = '0;
    dl_d[0].err  = !in_range;
    dl_d[0].we   = we_i;
    for (int i = 1; i < RespLatency; i++) begin
      dl_vld_d[i] = dl_vld_q[i-1];
      dl_d[i]     = stage_out[i-1];
    end
  end

  assign resp_push = dl_vld_q[RespLatency-1];
  assign credits_d = credits_q + CredW'(accept) - CredW'(retire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q    <= LfsrSeed;
      credits_q <= '0;
      dl_vld_q  <= '0;
      dl_q      <= '{default: '0};
    end else begin
      lfsr_q    <= lfsr_d;
      credits_q <= credits_d;
      dl_vld_q  <= dl_vld_d;
      dl_q      <= dl_d;
    end
  end

  tiny_mem_resp_fifo #(
    .Depth   (MaxOutstanding),
    .entry_t (resp_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (resp_push),
    .data_i  (stage_out[RespLatency-1]),
    .pop_i   (retire),
    .full_o  (resp_full),
    .empty_o (resp_empty),
    .head_o  (resp_head)
  );

  assign rvalid_o = !resp_empty;
  assign rerr_o   = rvalid_o && resp_head.err;
  assign rdata_o  = (rvalid_o && !resp_head.err && !resp_head.we) ?
                    DataWidth'(resp_head.data) : '0;

endmodule

// File: tb/tb_tiny_mem_ctrl.sv
// Scoreboard bench: dut_a (latency 1, depth 3) runs the main traffic, dut_b (latency 3,
// depth 4) runs the backpressure scenario.
module tb_tiny_mem_ctrl;

  localparam int unsigned NW   = 1024;
  localparam logic [63:0] Base = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall_en, req, we, rready;
  logic [63:0] addr, wdata;
  logic [7:0]  strb;
  logic        gnt, rvalid, rerr, sram_req, sram_we;
  logic [63:0] rdata, sram_wdata, sram_wmask;
  logic [9:0]  sram_addr;
  logic [63:0] sram_rdata = '0;

  logic        req_b, rready_b;
  logic [63:0] addr_b;
  logic        gnt_b, rvalid_b, rerr_b, sram_req_b, sram_we_b;
  logic [63:0] rdata_b, sram_wdata_b, sram_wmask_b;
  logic [9:0]  sram_addr_b;
  logic [63:0] sram_rdata_b = '0;

  tiny_mem_ctrl #(
    .AddrWidth(64), .DataWidth(64), .NumWords(NW), .BaseAddr(Base),
    .RespLatency(1), .MaxOutstanding(3), .LfsrSeed(16'hACE1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .stall_en_i(stall_en), .req_i(req), .gnt_o(gnt),
    .addr_i(addr), .we_i(we), .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid),
    .rready_i(rready), .rdata_o(rdata), .rerr_o(rerr), .sram_req_o(sram_req),
    .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
    .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata)
  );

  tiny_mem_ctrl #(
    .AddrWidth(64), .DataWidth(64), .NumWords(NW), .BaseAddr(Base),
    .RespLatency(3), .MaxOutstanding(4), .LfsrSeed(16'hACE1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .stall_en_i(1'b0), .req_i(req_b), .gnt_o(gnt_b),
    .addr_i(addr_b), .we_i(1'b0), .wdata_i(64'd0), .strb_i(8'd0), .rvalid_o(rvalid_b),
    .rready_i(rready_b), .rdata_o(rdata_b), .rerr_o(rerr_b), .sram_req_o(sram_req_b),
    .sram_we_o(sram_we_b), .sram_addr_o(sram_addr_b), .sram_wdata_o(sram_wdata_b),
    .sram_wmask_o(sram_wmask_b), .sram_rdata_i(sram_rdata_b)
  );

  // SRAM models: dut_a gets a real array, dut_b a ROM whose data encodes the word index.
  logic [63:0] sram_mem [NW] = '{default: '0};
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_wmask) |
                                          (sram_wdata & sram_wmask);
      else         sram_rdata <= sram_mem[sram_addr];
    end
    if (sram_req_b) sram_rdata_b <= {32'hA5A5_0000, 22'd0, sram_addr_b};
  end

  function automatic logic [63:0] pat(input int k);
    logic [9:0] w;
    w = 10'(k);
    return {32'hA5A5_0000, 22'd0, w};
  endfunction

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  typedef struct {
    logic        err;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] ref_mem [NW] = '{default: '0};
  bit          lat_chk = 1'b1;
  logic [63:0] last_rdata = '0;
  logic [63:0] m_off, m_mask;
  logic        m_in;
  logic [9:0]  m_idx;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid && rready) begin
        if (sb_q.size() == 0) begin
          check("resp_expected", {63'd0, rvalid}, 64'd0);
        end else begin
          m_e = sb_q.pop_front();
          check("rdata", rdata, m_e.data);
          check("rerr", {63'd0, rerr}, {63'd0, m_e.err});
          if (lat_chk) check("latency", 64'(cyc - m_e.cyc), 64'd1);
          last_rdata = rdata;
        end
      end
      if (req && gnt) begin
        m_off = addr - Base;
        m_in  = (addr >= Base) && (m_off < 64'(NW * 8));
        m_idx = m_off[12:3];
        for (int b = 0; b < 8; b++) m_mask[8*b +: 8] = {8{strb[b]}};
        if (m_in && we) ref_mem[m_idx] = (ref_mem[m_idx] & ~m_mask) | (wdata & m_mask);
        m_e.err  = !m_in;
        m_e.data = (m_in && !we) ? ref_mem[m_idx] : 64'd0;
        m_e.cyc  = cyc;
        sb_q.push_back(m_e);
      end
      if (dut_a.resp_push) check("push_when_full", {63'd0, dut_a.resp_full}, 64'd0);
    end
  end

  // Caller is just after a posedge; returns just after the posedge that accepted.
  task automatic xfer(input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] s, output logic sreq, output logic [9:0] saddr,
                      output logic [63:0] smask);
    logic got;
    got = 1'b0;
    req = 1'b1; we = w; addr = a; wdata = d; strb = s;
    sreq = 1'b0; saddr = '0; smask = '0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (gnt) begin
        got = 1'b1; sreq = sram_req; saddr = sram_addr; smask = sram_wmask;
      end
      @(posedge clk); #1;
    end
    check("xfer_granted", {63'd0, got}, 64'd1);
    req = 1'b0; we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
    check("drain_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic        sreq;
  logic [9:0]  saddr;
  logic [63:0] smask;
  int          n, k, nb, first_acc, first_rv;
  logic        acc;

  initial begin
    stall_en = 0; rready = 0; req = 1; we = 1; addr = Base; wdata = '1; strb = 8'hFF;
    req_b = 1; rready_b = 0; addr_b = Base;
    repeat (2) @(negedge clk);
    check("rst_gnt", {63'd0, gnt}, 64'd0);
    check("rst_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_sram_req", {63'd0, sram_req}, 64'd0);
    check("rst_sram_we", {63'd0, sram_we}, 64'd0);
    check("rst_wmask", sram_wmask, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_gnt_b", {63'd0, gnt_b}, 64'd0);
    @(posedge clk); #1;
    req = 0; we = 0; req_b = 0; rst_n = 1; rready = 1;
    @(posedge clk); #1;

    // Round trip and partial write
    xfer(1, Base + 8, 64'hDEADBEEF_CAFEF00D, 8'hFF, sreq, saddr, smask);
    check("wr_sreq", {63'd0, sreq}, 64'd1);
    check("wr_saddr", {54'd0, saddr}, 64'd1);
    xfer(0, Base + 8, 64'd0, 8'h00, sreq, saddr, smask);
    check("rd_saddr", {54'd0, saddr}, 64'd1);
    drain();
    check("rt_data", last_rdata, 64'hDEADBEEF_CAFEF00D);
    xfer(1, Base + 8, 64'h11111111_22222222, 8'h0F, sreq, saddr, smask);
    check("pw_mask", smask, 64'h00000000_FFFFFFFF);
    xfer(0, Base + 8, 64'd0, 8'h00, sreq, saddr, smask);
    drain();
    check("pw_data", last_rdata, 64'hDEADBEEF_22222222);

    // Range boundaries
    xfer(0, 64'h7FFF_FFF8, 64'd0, 8'h00, sreq, saddr, smask);
    check("oor_low_sreq", {63'd0, sreq}, 64'd0);
    xfer(0, Base + NW * 8, 64'd0, 8'h00, sreq, saddr, smask);
    check("oor_high_sreq", {63'd0, sreq}, 64'd0);
    xfer(1, Base + NW * 8, 64'hFFFF, 8'hFF, sreq, saddr, smask);
    check("oor_wr_sreq", {63'd0, sreq}, 64'd0);
    xfer(0, Base + (NW - 1) * 8 + 5, 64'd0, 8'h00, sreq, saddr, smask);
    check("top_word_saddr", {54'd0, saddr}, 64'(NW - 1));
    drain();

    for (int i = 0; i < 16; i++) begin
      xfer(1, Base + 64'(8 * i), {$urandom, $urandom}, 8'hFF, sreq, saddr, smask);
    end
    drain();

    // Throttled back-to-back reads
    stall_en = 1; req = 1; we = 0; k = 0; n = 0; addr = Base;
    for (int c = 0; c < 5000 && n < 1000; c++) begin
      @(negedge clk);
      check("gnt_lfsr", {63'd0, gnt}, {63'd0, lfsr_m[1:0] != 2'b00});
      acc = gnt;
      @(posedge clk); #1;
      if (acc) begin
        n++; k = (k + 1) % 16; addr = Base + 64'(8 * k);
      end
    end
    req = 0; stall_en = 0;
    check("thr_count", 64'(n), 64'd1000);
    drain();

    // Random mixed traffic with response backpressure
    lat_chk = 0;
    for (int c = 0; c < 300; c++) begin
      req    = $urandom_range(0, 3) != 0;
      we     = $urandom_range(0, 3) == 0;
      addr   = Base + 64'(8 * $urandom_range(0, 15));
      wdata  = {$urandom, $urandom};
      strb   = 8'($urandom);
      rready = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
    end
    req = 0; we = 0; rready = 1;
    drain();
    lat_chk = 1;

    // Credit limit on dut_b
    req_b = 1; rready_b = 0; addr_b = Base; nb = 0; first_acc = -1; first_rv = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      acc = gnt_b;
      if (acc && first_acc < 0) first_acc = cyc;
      if (rvalid_b && first_rv < 0) first_rv = cyc;
      @(posedge clk); #1;
      if (acc) begin
        nb++; addr_b = addr_b + 8;
      end
    end
    check("bp_grants", 64'(nb), 64'd4);
    @(negedge clk);
    check("bp_gnt_low", {63'd0, gnt_b}, 64'd0);
    check("bp_latency", 64'(first_rv - first_acc), 64'd3);
    check("bp_rvalid", {63'd0, rvalid_b}, 64'd1);
    check("bp_head", rdata_b, pat(0));
    @(posedge clk); #1;
    rready_b = 1;
    @(negedge clk);
    check("bp_regrant", {63'd0, gnt_b}, 64'd1);
    check("bp_retire_data", rdata_b, pat(0));
    @(posedge clk); #1;
    rready_b = 0;
    @(negedge clk);
    check("bp_relock", {63'd0, gnt_b}, 64'd0);
    check("bp_next_head", rdata_b, pat(1));
    @(posedge clk); #1;
    req_b = 0; rready_b = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("bp_drain_vld", {63'd0, rvalid_b}, 64'd1);
      check("bp_drain_data", rdata_b, pat(i));
      check("bp_drain_err", {63'd0, rerr_b}, 64'd0);
    end
    @(negedge clk);
    check("bp_empty", {63'd0, rvalid_b}, 64'd0);
    @(posedge clk); #1;
    rready_b = 0;

    // Reset with queued responses
    lat_chk = 0; rready = 0;
    for (int i = 0; i < 3; i++) xfer(0, Base + 64'(8 * i), 64'd0, 8'h00, sreq, saddr, smask);
    repeat (2) @(negedge clk);
    check("pre_rst_rvalid", {63'd0, rvalid}, 64'd1);
    @(posedge clk); #1;
    rst_n = 0; req = 1; addr = Base;
    #1;
    check("rst_kill_rvalid", {63'd0, rvalid}, 64'd0);
    check("rst_kill_gnt", {63'd0, gnt}, 64'd0);
    check("rst_kill_sreq", {63'd0, sram_req}, 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1; req = 0; rready = 1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_rvalid", {63'd0, rvalid}, 64'd0);
    end
    @(posedge clk); #1;
    lat_chk = 1;
    xfer(0, Base + 16, 64'd0, 8'h00, sreq, saddr, smask);
    drain();
    check("post_rst_data", last_rdata, ref_mem[2]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
